mem_stage_seq: RTL and testbench
================================

MEM_STAGE_SEQ -- requirements
Module: mem_stage_seq

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter ADDR_W, default 16: byte address width.
REQ-003 Parameter IND_DEPTH, default 1: pointer-dereference levels performed for indirect ops, range 1..4.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  memory-stage instruction valid.
REQ-007 req_op  in  3  lc3b_mem_op: NONE, LD, ST, LDB, STB, LDI, STI.
REQ-008 req_addr  in  ADDR_W  effective address from the execute stage.
REQ-009 req_wdata  in  DATA_W  store data.
REQ-010 mem_resp  in  1  data-port response; one cycle per completed access.
REQ-011 mem_rdata  in  DATA_W  data-port read data; valid only while mem_resp is high.
REQ-012 mem_read, mem_write  out  1 each  data-port strobes; never both high.
REQ-013 mem_address  out  ADDR_W  data-port address.
REQ-014 mem_wdata  out  DATA_W  data-port write data.
REQ-015 mem_wmask  out  DATA_W/8  byte-lane write enables.
REQ-016 stall  out  1  high: upstream stages hold.
REQ-017 rsp_valid  out  1  one-cycle completion pulse.
REQ-018 rsp_rdata  out  DATA_W  load result; a byte result is sign-extended.
REQ-019 misaligned  out  1  one-cycle pulse when a word op presents an odd address.

Function
REQ-020 The FSM SHALL have the states IDLE, INDIR, ACCESS and DONE.
REQ-021 IDLE: on req_valid with op other than NONE, SHALL latch op, address and wdata, load the indirection counter with IND_DEPTH, and go to INDIR for LDI/STI or ACCESS otherwise; with op NONE, no state change.
REQ-022 INDIR: SHALL hold mem_read high at the latched address until mem_resp; on mem_resp it SHALL load the address from mem_rdata with the LSB cleared and decrement the counter, then go to ACCESS at zero, else stay in INDIR.
REQ-023 ACCESS: SHALL hold the read or write strobe until mem_resp, with address, wdata and mask stable; on mem_resp it SHALL capture the result into rsp_rdata and go to DONE.
REQ-024 DONE: rsp_valid=1 and stall=0 for exactly one cycle, then IDLE.
REQ-025 stall SHALL equal req_valid and (op not NONE) and (state not DONE).
REQ-026 Latency: an access with zero wait states SHALL complete in 3 cycles (IDLE, ACCESS, DONE); each indirection level adds 1 cycle plus its wait states.
REQ-027 Word ops (LD/ST/LDI/STI final access) SHALL drive the address with the LSB forced to 0, all-ones mask; an odd requested address SHALL pulse misaligned in the latch cycle.
REQ-028 STB: wdata SHALL be the low byte replicated across all lanes; mask one-hot at lane addr[log2(DATA_W/8)-1:0].
REQ-029 LDB: rsp_rdata SHALL be the addressed byte lane, sign-extended to DATA_W.
REQ-030 Inputs SHALL be ignored outside IDLE; a req_valid that drops mid-operation SHALL NOT abort it.
REQ-031 mem_resp arriving while neither strobe is high SHALL be ignored.
REQ-032 Idle outputs: strobes 0, mask 0, rsp_valid 0; address/wdata hold their last values.

Reset
REQ-033 reset SHALL force IDLE, clear the counter and latched request, and zero every output in the next cycle, including mid-INDIR/ACCESS; a pending mem_resp after reset SHALL be ignored.

Structure
REQ-034 lc3b_mem_op and the FSM state enum SHALL live in lc3b_types; parameters remain local.
REQ-035 Lane select, replication, mask and sign-extension SHALL be one combinational sub-module, byte_lane, parametrised by DATA_W.

Verification (DATA_W=16, IND_DEPTH=1)
REQ-036 LD 0x1000, resp after 3 wait cycles with 0xBEEF -> mem_read cycles 1-4, rsp_valid cycle 5 with 0xBEEF, stall high cycles 0-4.
REQ-037 STB 0x2001, wdata 0x00AB -> mem_wdata 0xABAB, mem_wmask 2'b10, mem_write until resp.
REQ-038 LDI 0x3000, pointer 0x4001, data 0x1234 -> reads at 0x3000 then 0x4000, rsp_rdata 0x1234.
REQ-039 LDB 0x5001, rdata 0x80FF -> rsp_rdata 0xFF80.
REQ-040 LD 0x6003 -> mem_address 0x6002, misaligned pulses once.
REQ-041 reset mid-ACCESS, then mem_resp -> next cycle strobes 0, stall 0, state IDLE, no rsp_valid.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b memory stage.
//   lc3b_mem_op  - memory-stage operation code carried by req_op
//   mem_state_e  - control FSM state of mem_stage_seq
//   op_* helpers - classify an operation (active, indirect, store, byte)
package lc3b_types;

    typedef enum logic [2:0] {
        MOP_NONE = 3'd0,
        MOP_LD   = 3'd1,
        MOP_ST   = 3'd2,
        MOP_LDB  = 3'd3,
        MOP_STB  = 3'd4,
        MOP_LDI  = 3'd5,
        MOP_STI  = 3'd6
    } lc3b_mem_op;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INDIR,
        S_ACCESS,
        S_DONE
    } mem_state_e;

    // Code 3'd7 is unassigned and is treated exactly like NONE.
    function automatic logic op_active(lc3b_mem_op op);
        return op inside {MOP_LD, MOP_ST, MOP_LDB, MOP_STB, MOP_LDI, MOP_STI};
    endfunction

    function automatic logic op_indirect(lc3b_mem_op op);
        return op inside {MOP_LDI, MOP_STI};
    endfunction

    function automatic logic op_store(lc3b_mem_op op);
        return op inside {MOP_ST, MOP_STB, MOP_STI};
    endfunction

    function automatic logic op_byte(lc3b_mem_op op);
        return op inside {MOP_LDB, MOP_STB};
    endfunction

    function automatic logic op_word(lc3b_mem_op op);
        return op_active(op) && !op_byte(op);
    endfunction

endpackage

// File: rtl/byte_lane.sv
// byte_lane: combinational byte-lane steering for the data port.
//   lane      in  byte lane index (low address bits)
//   byte_op   in  1 = byte access (LDB/STB), 0 = full-word access
//   wdata_in  in  store data as latched from the pipeline
//   rdata_in  in  raw data-port read data
//   wdata_out out store data; byte ops replicate the low byte to all lanes
//   mask      out lane enables; one-hot for byte ops, all ones for word ops
//   rdata_out out load result; byte ops return the selected lane sign-extended
module byte_lane #(
    parameter  int DATA_W = 16,
    localparam int LANES  = DATA_W / 8,
    localparam int LW     = $clog2(LANES)
) (
    input  logic [LW-1:0]     lane,
    input  logic              byte_op,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [DATA_W-1:0] wdata_out,
    output logic [LANES-1:0]  mask,
    output logic [DATA_W-1:0] rdata_out
);

    logic [7:0] sel_byte;

    always_comb begin
        wdata_out = wdata_in;
        mask      = '1;
        rdata_out = rdata_in;
        sel_byte  = '0;
        if (byte_op) begin
            wdata_out = {LANES{wdata_in[7:0]}};
            mask      = '0;
            for (int i = 0; i < LANES; i++) begin
                if (lane == LW'(i)) begin
                    mask[i]  = 1'b1;
                    sel_byte = rdata_in[i*8 +: 8];
                end
            end
            rdata_out = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
        end
    end

endmodule

// File: rtl/mem_stage_seq.sv
// mem_stage_seq: LC-3b memory stage sequencer with pointer indirection.
// Accepts one memory op in IDLE, optionally walks IND_DEPTH pointer reads
// (LDI/STI), performs the final data-port access, then pulses rsp_valid.
//   clk, reset                   clock, synchronous active-high reset
//   req_valid/op/addr/wdata      request from execute (sampled in IDLE only)
//   mem_resp, mem_rdata          data-port completion and read data
//   mem_read, mem_write          data-port strobes (mutually exclusive)
//   mem_address/wdata/wmask      data-port address, store data, lane enables
//   stall                        hold upstream while the op is in flight
//   rsp_valid, rsp_rdata         completion pulse and load result
//   misaligned                   word op presented with an odd address
module mem_stage_seq
    import lc3b_types::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int IND_DEPTH = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [2:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic                stall,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                misaligned
);

    localparam int LANES = DATA_W / 8;
    localparam int LW    = $clog2(LANES);
    localparam int CNT_W = 3;

    mem_state_e        state_q, state_d;
    lc3b_mem_op        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    lc3b_mem_op        req_op_e;
    logic [ADDR_W-1:0] ptr_addr;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic [LANES-1:0]  lane_mask;

    assign req_op_e = lc3b_mem_op'(req_op);

    byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
        .lane      (addr_q[LW-1:0]),
        .byte_op   (op_byte(op_q)),
        .wdata_in  (wdata_q),
        .rdata_in  (mem_rdata),
        .wdata_out (lane_wdata),
        .mask      (lane_mask),
        .rdata_out (lane_rdata)
    );

    // Pointer fetched during indirection; always word aligned.
    always_comb begin
        ptr_addr    = ADDR_W'(mem_rdata);
        ptr_addr[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && op_active(req_op_e)) begin
                    op_d    = req_op_e;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(IND_DEPTH);
                    state_d = op_indirect(req_op_e) ? S_INDIR : S_ACCESS;
                end
            end
            S_INDIR: begin
                if (mem_resp) begin
                    addr_d = ptr_addr;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_resp) begin
                    // Stores leave the previous load result untouched.
                    if (!op_store(op_q)) rdata_d = lane_rdata;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= MOP_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Pointer reads use the raw latched address; the final word access is
    // aligned. Keying on op_q (not state) keeps the address stable in IDLE.
    always_comb begin
        mem_address = addr_q;
        if (op_word(op_q) && state_q != S_INDIR) begin
            mem_address = {addr_q[ADDR_W-1:1], 1'b0};
        end
    end

    assign mem_read   = (state_q == S_INDIR) ||
                        (state_q == S_ACCESS && !op_store(op_q));
    assign mem_write  = (state_q == S_ACCESS) && op_store(op_q);
    assign mem_wdata  = lane_wdata;
    assign mem_wmask  = (state_q == S_ACCESS) ? lane_mask : '0;
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_rdata  = rdata_q;
    assign stall      = req_valid && op_active(req_op_e) && (state_q != S_DONE);
    assign misaligned = (state_q == S_IDLE) && req_valid &&
                        op_word(req_op_e) && req_addr[0];

endmodule

// File: tb/tb_mem_stage_seq.sv
module tb_mem_stage_seq;

    localparam logic [2:0] OP_LD  = 3'd1;
    localparam logic [2:0] OP_ST  = 3'd2;
    localparam logic [2:0] OP_LDB = 3'd3;
    localparam logic [2:0] OP_STB = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_STI = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wmask;
    logic        stall, rsp_valid, misaligned;
    logic [15:0] rsp_rdata;

    mem_stage_seq #(.DATA_W(16), .ADDR_W(16), .IND_DEPTH(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory the bench serves from, and an independent reference image.
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    // Per-cycle trace of the last transaction (index = cycle from latch).
    logic        stall_tr[$], rd_tr[$], wr_tr[$], mis_tr[$];
    logic [15:0] addr_tr[$], wdata_tr[$];
    logic [1:0]  mask_tr[$];
    logic [15:0] acc_q[$];
    int          rsp_cyc;
    logic [15:0] got;

    // Reference model outputs.
    logic [15:0] exp_acc[$];
    logic [15:0] exp_rd;
    int          exp_widx;
    bit          exp_load;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        mem[a[15:1]]     = v;
        ref_mem[a[15:1]] = v;
    endtask

    // Architectural effect of one op: list of data-port addresses, load
    // result, and the store applied to the reference image.
    task automatic model(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd);
        int ea, w, b;
        exp_acc.delete();
        exp_rd   = 16'h0;
        exp_load = (op == OP_LD || op == OP_LDB || op == OP_LDI);
        ea = int'(addr);
        if (op == OP_LDI || op == OP_STI) begin
            exp_acc.push_back(addr);
            ea = (int'(ref_mem[addr / 2]) / 2) * 2;
        end
        w = ea / 2;
        exp_widx = w;
        case (op)
            OP_LD, OP_LDI: begin
                exp_acc.push_back(16'(w * 2));
                exp_rd = ref_mem[w];
            end
            OP_ST, OP_STI: begin
                exp_acc.push_back(16'(w * 2));
                ref_mem[w] = wd;
            end
            OP_LDB: begin
                exp_acc.push_back(16'(ea));
                b = (ea % 2 == 1) ? int'(ref_mem[w]) / 256 : int'(ref_mem[w]) % 256;
                exp_rd = 16'((b >= 128) ? b + 65280 : b);
            end
            OP_STB: begin
                exp_acc.push_back(16'(ea));
                if (ea % 2 == 1)
                    ref_mem[w] = 16'((int'(ref_mem[w]) % 256) + (int'(wd) % 256) * 256);
                else
                    ref_mem[w] = 16'((int'(ref_mem[w]) / 256) * 256 + (int'(wd) % 256));
            end
            default: ;
        endcase
    endtask

    // Runs one op with a memory responder inserting `waits` wait states per
    // access. Entered and left at posedge+1. With scramble set, request
    // inputs are randomised after the latch cycle.
    task automatic txn(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd,
                       input int waits, input bit scramble);
        int  cyc = 0;
        int  w   = 0;
        bit  done = 0;
        bit  exp_mis;
        model(op, addr, wd);
        stall_tr.delete(); rd_tr.delete(); wr_tr.delete(); mis_tr.delete();
        addr_tr.delete(); wdata_tr.delete(); mask_tr.delete(); acc_q.delete();
        rsp_cyc = -1;
        got = 16'h0;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; mem_resp = 1'b0;
        while (!done) begin
            #1;
            stall_tr.push_back(stall); rd_tr.push_back(mem_read); wr_tr.push_back(mem_write);
            mis_tr.push_back(misaligned); addr_tr.push_back(mem_address);
            wdata_tr.push_back(mem_wdata); mask_tr.push_back(mem_wmask);
            if (mem_read && mem_write) chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
            mem_resp  = 1'b0;
            mem_rdata = 16'($urandom);
            if (rsp_valid) begin
                done = 1; rsp_cyc = cyc; got = rsp_rdata;
                req_valid = 1'b0;
            end else if (mem_read || mem_write) begin
                if (w < waits) w++;
                else begin
                    w = 0;
                    mem_resp = 1'b1;
                    acc_q.push_back(mem_address);
                    if (mem_read) mem_rdata = mem[mem_address[15:1]];
                    else
                        for (int b = 0; b < 2; b++)
                            if (mem_wmask[b]) mem[mem_address[15:1]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
            end
            if (!done && cyc >= 60) begin
                chk("timeout", 32'd1, 32'd0);
                done = 1;
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (scramble && !done) begin
                req_valid = 1'($urandom); req_op = 3'($urandom_range(0, 6));
                req_addr = 16'($urandom); req_wdata = 16'($urandom);
            end
        end
        mem_resp = 1'b0;
        #1 chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("acc_count", 32'(acc_q.size()), 32'(exp_acc.size()));
        for (int i = 0; i < acc_q.size() && i < exp_acc.size(); i++)
            chk("acc_addr", 32'(acc_q[i]), 32'(exp_acc[i]));
        if (exp_load) chk("rsp_rdata", 32'(got), 32'(exp_rd));
        else chk("store_mem", 32'(mem[exp_widx]), 32'(ref_mem[exp_widx]));
        chk("latency", 32'(rsp_cyc), 32'(exp_acc.size() * (waits + 1) + 1));
        exp_mis = (op == OP_LD || op == OP_ST || op == OP_LDI || op == OP_STI) && addr[0];
        chk("mis_latch", 32'(mis_tr[0]), 32'(exp_mis));
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [2:0] rop;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        #1;
        chk("rst_read",  32'(mem_read),    32'd0);
        chk("rst_write", 32'(mem_write),   32'd0);
        chk("rst_addr",  32'(mem_address), 32'd0);
        chk("rst_wdata", 32'(mem_wdata),   32'd0);
        chk("rst_mask",  32'(mem_wmask),   32'd0);
        chk("rst_stall", 32'(stall),       32'd0);
        chk("rst_rspv",  32'(rsp_valid),   32'd0);
        chk("rst_rspd",  32'(rsp_rdata),   32'd0);
        chk("rst_mis",   32'(misaligned),  32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // LD with three wait states.
        poke(16'h1000, 16'hBEEF);
        txn(OP_LD, 16'h1000, 16'h0, 3, 0);
        chk("ld_rdata", 32'(got), 32'hBEEF);
        chk("ld_rsp_cyc", 32'(rsp_cyc), 32'd5);
        chk("ld_rd_c0", 32'(rd_tr[0]), 32'd0);
        for (int c = 1; c <= 4; c++) chk("ld_rd_c", 32'(rd_tr[c]), 32'd1);
        chk("ld_rd_c5", 32'(rd_tr[5]), 32'd0);
        for (int c = 0; c <= 4; c++) chk("ld_stall_c", 32'(stall_tr[c]), 32'd1);
        chk("ld_stall_c5", 32'(stall_tr[5]), 32'd0);

        // STB to the odd byte: replicated data, upper-lane mask.
        poke(16'h2000, 16'h1234);
        txn(OP_STB, 16'h2001, 16'h00AB, 1, 0);
        chk("stb_wdata", 32'(wdata_tr[1]), 32'hABAB);
        chk("stb_mask",  32'(mask_tr[1]),  32'h2);
        chk("stb_wr_c1", 32'(wr_tr[1]), 32'd1);
        chk("stb_wr_c2", 32'(wr_tr[2]), 32'd1);
        chk("stb_mem",   32'(mem[16'h1000]), 32'hAB34);

        // LDI through an odd pointer.
        poke(16'h3000, 16'h4001);
        poke(16'h4000, 16'h1234);
        txn(OP_LDI, 16'h3000, 16'h0, 0, 0);
        chk("ldi_rdata", 32'(got), 32'h1234);
        chk("ldi_addr0", 32'(addr_tr[1]), 32'h3000);
        chk("ldi_addr1", 32'(addr_tr[2]), 32'h4000);

        // LDB sign extension, both lanes.
        poke(16'h5000, 16'h80FF);
        txn(OP_LDB, 16'h5001, 16'h0, 0, 0);
        chk("ldb_hi", 32'(got), 32'hFF80);
        poke(16'h5002, 16'h8075);
        txn(OP_LDB, 16'h5002, 16'h0, 2, 0);
        chk("ldb_lo", 32'(got), 32'h0075);

        // Odd word address: aligned access, single misaligned pulse.
        txn(OP_LD, 16'h6003, 16'h0, 0, 0);
        chk("mis_addr", 32'(addr_tr[1]), 32'h6002);
        n = 0;
        foreach (mis_tr[k]) n += int'(mis_tr[k]);
        chk("mis_count", 32'(n), 32'd1);

        // Reset mid-ACCESS, then a stale response.
        req_valid = 1'b1; req_op = OP_LD; req_addr = 16'h7000; mem_resp = 1'b0;
        @(posedge clk); #1;
        #1 chk("rstm_read", 32'(mem_read), 32'd1);
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h5555;
        #1;
        chk("rstm_read0",  32'(mem_read),    32'd0);
        chk("rstm_write0", 32'(mem_write),   32'd0);
        chk("rstm_stall",  32'(stall),       32'd0);
        chk("rstm_rspv",   32'(rsp_valid),   32'd0);
        chk("rstm_addr",   32'(mem_address), 32'd0);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        #1;
        chk("rstm_rspv2", 32'(rsp_valid), 32'd0);
        chk("rstm_read2", 32'(mem_read),  32'd0);
        @(posedge clk); #1;
        poke(16'h7000, 16'h0F0F);
        txn(OP_LD, 16'h7000, 16'h0, 0, 0);
        chk("rstm_after", 32'(got), 32'h0F0F);

        // Random ops with wait states and request inputs churning mid-op.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(1, 6));
            txn(rop, 16'($urandom), 16'($urandom), $urandom_range(0, 3), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
